// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory read port, downstream stall,
// execute-stage redirect and the registered fetch/execute outputs.
//   master  : the fetch stage (drives imem_req/addr and out_*)
//   slave   : the environment (imem, execute stage, pipeline register)
// Optional macro FETCH_MISALIGN_CHECK_EN adds out_misaligned.
interface fetch_stage_if #(
  parameter int unsigned data_width = 32
);
  logic                  imem_req;
  logic [data_width-1:0] imem_addr;
  logic [data_width-1:0] imem_rdata;
  logic                  stall_i;
  logic                  redirect_valid;
  logic [data_width-1:0] redirect_pc;
  logic                  out_valid;
  logic [data_width-1:0] out_pc;
  logic [data_width-1:0] out_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic                  out_misaligned;
`endif

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
`ifdef FETCH_MISALIGN_CHECK_EN
    output out_misaligned,
`endif
    input  imem_rdata, stall_i, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
`ifdef FETCH_MISALIGN_CHECK_EN
    input  out_misaligned,
`endif
    output imem_rdata, stall_i, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of a 3-stage RV32I pipeline.
// Holds the PC, issues word reads to a 1-cycle-latency synchronous imem,
// presents {pc, instr, valid} through registered outputs, absorbs downstream
// stalls with a 1-entry skid buffer and flushes on branch/jump redirects.
// Ports:
//   clock    : rising-edge clock
//   reset    : synchronous, active-high reset
//   fetch_io : fetch_stage_if.master (imem port, stall, redirect, outputs)
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect target traps
// (one out_misaligned=1 output, then idle until an aligned redirect/reset).
// Without it, redirect target bits [1:0] are silently cleared.
module fetch_stage #(
  parameter int unsigned           data_width = 32,
  parameter logic [data_width-1:0] RESET_PC   = '0,
  parameter logic [data_width-1:0] NOP_INSTR  = data_width'(32'h0000_0013)
) (
  input logic             clock,
  input logic             reset,
  fetch_stage_if.master   fetch_io
);

  logic [data_width-1:0] pc_d, pc_q;
  logic [data_width-1:0] req_pc_d, req_pc_q;
  logic                  inflight_d, inflight_q;
  logic                  skid_valid_d, skid_valid_q;
  logic [data_width-1:0] skid_pc_d, skid_pc_q;
  logic [data_width-1:0] skid_instr_d, skid_instr_q;
  logic                  out_valid_d, out_valid_q;
  logic [data_width-1:0] out_pc_d, out_pc_q;
  logic [data_width-1:0] out_instr_d, out_instr_q;

  logic hold;
  logic issue;
  logic trap_block;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {StRun, StTrapPend, StTrapped} state_e;
  state_e                state_d, state_q;
  logic [data_width-1:0] trap_pc_d, trap_pc_q;
  logic                  out_mis_d, out_mis_q;
  assign trap_block = (state_q != StRun);
  assign fetch_io.out_misaligned = out_mis_q;
`else
  assign trap_block = 1'b0;
`endif

  // A stall only matters when there is a live instruction to hold.
  assign hold  = fetch_io.stall_i && out_valid_q;
  // With a hold pending, a new read is only safe if the skid slot is free
  // and nothing is already in flight to fill it.
  assign issue = !reset && !fetch_io.redirect_valid && !trap_block &&
                 !(hold && (skid_valid_q || inflight_q));

  assign fetch_io.imem_req  = issue;
  assign fetch_io.imem_addr = pc_q;
  assign fetch_io.out_valid = out_valid_q;
  assign fetch_io.out_pc    = out_pc_q;
  assign fetch_io.out_instr = out_instr_q;

  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inflight_d   = inflight_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    state_d      = state_q;
    trap_pc_d    = trap_pc_q;
    out_mis_d    = out_mis_q;
`endif

    if (fetch_io.redirect_valid) begin
      // Flush: drop output, skid contents and any returning read.
      out_valid_d  = 1'b0;
      out_instr_d  = NOP_INSTR;
      skid_valid_d = 1'b0;
      inflight_d   = 1'b0;
      pc_d         = fetch_io.redirect_pc & ~data_width'(3);
`ifdef FETCH_MISALIGN_CHECK_EN
      out_mis_d = 1'b0;
      if (fetch_io.redirect_pc[1:0] != 2'b00) begin
        state_d   = StTrapPend;
        trap_pc_d = fetch_io.redirect_pc;
      end else begin
        state_d = StRun;
      end
`endif
    end else begin
      inflight_d = issue;
      if (issue) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + data_width'(4);
      end

      if (hold) begin
        if (inflight_q) begin
          skid_valid_d = 1'b1;
          skid_pc_d    = req_pc_q;
          skid_instr_d = fetch_io.imem_rdata;
        end
      end else if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_pc_d     = skid_pc_q;
        out_instr_d  = skid_instr_q;
        skid_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        out_mis_d    = 1'b0;
`endif
      end else if (inflight_q) begin
        out_valid_d = 1'b1;
        out_pc_d    = req_pc_q;
        out_instr_d = fetch_io.imem_rdata;
`ifdef FETCH_MISALIGN_CHECK_EN
        out_mis_d   = 1'b0;
      end else if (state_q == StTrapPend) begin
        out_valid_d = 1'b1;
        out_pc_d    = trap_pc_q;
        out_instr_d = NOP_INSTR;
        out_mis_d   = 1'b1;
        state_d     = StTrapped;
`endif
      end else begin
        out_valid_d = 1'b0;
        out_instr_d = NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
        out_mis_d   = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      inflight_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_instr_q  <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
      state_q      <= StRun;
      trap_pc_q    <= '0;
      out_mis_q    <= 1'b0;
`endif
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inflight_q   <= inflight_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      state_q      <= state_d;
      trap_pc_q    <= trap_pc_d;
      out_mis_q    <= out_mis_d;
`endif
    end
  end

  // A full skid plus an in-flight read under hold would lose data.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(skid_valid_q && inflight_q && hold));

endmodule
